// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller Avalon-MM slave.
// Read responses return to the issuing master through an in-order tag FIFO.
//
// state | meaning
// IDLE  | no grant; controller sees no command, both masters stalled
// GNT0  | master 0 (pixel-read DMA) owns the controller port
// GNT1  | master 1 (result-write DMA) owns the controller port
module sdram_port_arbiter #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8,
  parameter int MAX_PEND  = 8
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [ADDR_W-1:0]            m0_address,
  input  logic                         m0_read,
  input  logic                         m0_write,
  input  logic [DATA_W-1:0]            m0_writedata,
  input  logic [DATA_W/8-1:0]          m0_byteenable,
  output logic                         m0_waitrequest,
  output logic [DATA_W-1:0]            m0_readdata,
  output logic                         m0_readdatavalid,
  input  logic [ADDR_W-1:0]            m1_address,
  input  logic                         m1_read,
  input  logic                         m1_write,
  input  logic [DATA_W-1:0]            m1_writedata,
  input  logic [DATA_W/8-1:0]          m1_byteenable,
  output logic                         m1_waitrequest,
  output logic [DATA_W-1:0]            m1_readdata,
  output logic                         m1_readdatavalid,
  output logic [ADDR_W-1:0]            s_address,
  output logic                         s_read,
  output logic                         s_write,
  output logic [DATA_W-1:0]            s_writedata,
  output logic [DATA_W/8-1:0]          s_byteenable,
  input  logic                         s_waitrequest,
  input  logic [DATA_W-1:0]            s_readdata,
  input  logic                         s_readdatavalid,
  output logic                         err_orphan,
  output logic [$clog2(MAX_PEND):0]    pend_count
);

  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND) + 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nx;
  logic          last_gnt, last_gnt_nx;
  logic [BW-1:0] beat_cnt, beat_cnt_nx;

  logic          tag_mem [MAX_PEND];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic req0, req1;
  logic sel_read, sel_write;
  logic read_block, accept, push, pop, orphan;
  logic fifo_full, fifo_empty, head_tag;

  function automatic state_t arbitrate(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? GNT0 : GNT1;
    if (r0)       return GNT0;
    if (r1)       return GNT1;
    return IDLE;
  endfunction

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign fifo_full  = (count == CW'(MAX_PEND));
  assign fifo_empty = (count == '0);
  assign head_tag   = tag_mem[rd_ptr];
  assign pop        = s_readdatavalid & ~fifo_empty;
  assign orphan     = s_readdatavalid & fifo_empty;

  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    sel_read     = 1'b0;
    sel_write    = 1'b0;
    unique case (state)
      GNT0: begin
        s_address    = m0_address;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        sel_read     = m0_read;
        sel_write    = m0_write & ~m0_read;
      end
      GNT1: begin
        s_address    = m1_address;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        sel_read     = m1_read;
        sel_write    = m1_write & ~m1_read;
      end
      default: ;
    endcase
  end

  // A response popping in the same cycle frees a slot, so a full FIFO still takes the read.
  assign read_block = sel_read & fifo_full & ~pop;
  assign s_read     = sel_read & ~read_block & ~reset_reset;
  assign s_write    = sel_write & ~reset_reset;
  assign accept     = (s_read | s_write) & ~s_waitrequest;
  assign push       = s_read & ~s_waitrequest;

  assign m0_waitrequest = (state != GNT0) | s_waitrequest | read_block | reset_reset;
  assign m1_waitrequest = (state != GNT1) | s_waitrequest | read_block | reset_reset;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head_tag & ~reset_reset;
  assign m1_readdatavalid = pop &  head_tag & ~reset_reset;
  assign pend_count       = count;

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    beat_cnt_nx = beat_cnt;
    unique case (state)
      IDLE: state_nx = arbitrate(req0, req1, last_gnt);
      GNT0: begin
        if (!req0 || (accept && beat_cnt == BW'(BURST_MAX - 1))) begin
          last_gnt_nx = 1'b0;
          beat_cnt_nx = '0;
          state_nx    = arbitrate(req0, req1, 1'b0);
        end else if (accept) begin
          beat_cnt_nx = beat_cnt + BW'(1);
        end
      end
      GNT1: begin
        if (!req1 || (accept && beat_cnt == BW'(BURST_MAX - 1))) begin
          last_gnt_nx = 1'b1;
          beat_cnt_nx = '0;
          state_nx    = arbitrate(req0, req1, 1'b1);
        end else if (accept) begin
          beat_cnt_nx = beat_cnt + BW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      beat_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      state    <= state_nx;
      last_gnt <= last_gnt_nx;
      beat_cnt <= beat_cnt_nx;
      if (push) wr_ptr <= (wr_ptr == PW'(MAX_PEND - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_PEND - 1)) ? '0 : rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (orphan) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) tag_mem[wr_ptr] <= (state == GNT1);
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant order, burst rotation, tag routing,
// FIFO-full blocking, controller stall and reset with reads outstanding.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  logic clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  logic              reset_reset;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]        m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic              err_orphan;
  logic [3:0]        pend_count;

  logic              drv_rdv;
  logic [DATA_W-1:0] drv_rdata;
  logic              pipe_en;
  logic [4:0]        pv = '0;
  logic [DATA_W-1:0] pd [5];

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int rsp_tag [$];
  logic [DATA_W-1:0] rsp_data [$];

  sdram_port_arbiter dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan), .pend_count(pend_count)
  );

  // Controller model: fixed-latency read response, data = address + 0x1000_0000.
  assign s_readdatavalid = drv_rdv | (pipe_en & pv[4]);
  assign s_readdata      = drv_rdv ? drv_rdata : pd[4];

  always @(posedge clk_clk) begin
    if (reset_reset) pv <= '0;
    else             pv <= {pv[3:0], s_read & ~s_waitrequest};
    pd[0] <= {10'h0, s_address} + 32'h1000_0000;
    for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
  end

  always @(negedge clk_clk) begin
    if (s_read & ~s_waitrequest) acc_cnt++;
    if (m0_readdatavalid) begin rsp_tag.push_back(0); rsp_data.push_back(m0_readdata); end
    if (m1_readdatavalid) begin rsp_tag.push_back(1); rsp_data.push_back(m1_readdata); end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_reset;
    reset_reset   = 1'b1;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    s_waitrequest = 1'b0;
    drv_rdv = 1'b0; drv_rdata = '0;
    repeat (2) tick();
    reset_reset = 1'b0;
  endtask

  // Holds a read on master mst until the port accepts it; returns just after the accepting edge.
  task automatic issue(input int mst, input logic [ADDR_W-1:0] a);
    logic ok;
    if (mst == 0) begin m0_address = a; m0_read = 1'b1; end
    else          begin m1_address = a; m1_read = 1'b1; end
    for (int k = 0; k < 40; k++) begin
      #1;
      ok = (mst == 0) ? ~m0_waitrequest : ~m1_waitrequest;
      tick();
      if (ok) return;
    end
    chk("issue_timeout", 0, 1);
  endtask

  int base, a0, g;
  int exp_tag [5] = '{0, 0, 0, 1, 1};
  logic [ADDR_W-1:0] exp_addr [5] = '{22'h30, 22'h31, 22'h32, 22'h40, 22'h41};

  initial begin
    pipe_en = 1'b0;
    do_reset();
    #1;
    chk("rst_pend", pend_count, 0);
    chk("rst_orphan", err_orphan, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);

    // single master read
    m0_address = 22'h10; m0_read = 1'b1; #1;
    chk("t1_idle_s_read", s_read, 0);
    tick(); #1;
    chk("t1_s_read", s_read, 1);
    chk("t1_s_addr", s_address, 22'h10);
    chk("t1_m0_wait", m0_waitrequest, 0);
    chk("t1_m1_wait", m1_waitrequest, 1);
    tick(); m0_read = 1'b0; #1;
    chk("t1_pend1", pend_count, 1);
    tick(); tick();
    drv_rdata = 32'hDEADBEEF; drv_rdv = 1'b1; #1;
    chk("t1_m0_rdv", m0_readdatavalid, 1);
    chk("t1_m0_data", m0_readdata, 32'hDEADBEEF);
    chk("t1_m1_rdv", m1_readdatavalid, 0);
    tick(); drv_rdv = 1'b0; #1;
    chk("t1_pend0", pend_count, 0);
    chk("t1_m0_rdv_end", m0_readdatavalid, 0);

    // tie from reset, burst lock of 8, rotation without bubble
    do_reset();
    m0_write = 1'b1; m0_address = 22'h100; m0_writedata = 32'h11; m0_byteenable = 4'hF;
    m1_write = 1'b1; m1_address = 22'h200; m1_writedata = 32'h22; m1_byteenable = 4'h3;
    for (int i = 0; i < 18; i++) begin
      #1;
      g = ~m0_waitrequest ? 0 : (~m1_waitrequest ? 1 : 2);
      chk($sformatf("t2_gnt_c%0d", i), g, (i == 0) ? 2 : ((i - 1) / 8) % 2);
      if (i == 1) begin
        chk("t2_s_addr0", s_address, 22'h100);
        chk("t2_s_wdata0", s_writedata, 32'h11);
      end
      if (i == 9) begin
        chk("t2_s_addr1", s_address, 22'h200);
        chk("t2_s_be1", s_byteenable, 4'h3);
        chk("t2_s_write1", s_write, 1);
      end
      tick();
    end
    m0_write = 1'b0; m1_write = 1'b0;

    // interleaved reads with 5-cycle latency
    do_reset();
    pipe_en = 1'b1;
    base = rsp_tag.size();
    issue(0, 22'h30); issue(0, 22'h31); issue(0, 22'h32);
    m0_read = 1'b0;
    issue(1, 22'h40); issue(1, 22'h41);
    m1_read = 1'b0;
    repeat (15) tick();
    chk("t3_rsp_count", rsp_tag.size() - base, 5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < rsp_tag.size()) begin
        chk($sformatf("t3_tag%0d", k), rsp_tag[base+k], exp_tag[k]);
        chk($sformatf("t3_data%0d", k), rsp_data[base+k], {10'h0, exp_addr[k]} + 32'h1000_0000);
      end
    end
    chk("t3_pend", pend_count, 0);
    pipe_en = 1'b0;

    // FIFO full with responses withheld
    do_reset();
    a0 = acc_cnt;
    m0_address = 22'h50; m0_read = 1'b1;
    repeat (12) tick();
    #1;
    chk("t4_accepted", acc_cnt - a0, 8);
    chk("t4_s_read_blk", s_read, 0);
    chk("t4_m0_wait_blk", m0_waitrequest, 1);
    chk("t4_pend_full", pend_count, 8);
    drv_rdata = 32'h5555; drv_rdv = 1'b1; #1;
    chk("t4_s_read_pp", s_read, 1);
    chk("t4_m0_rdv_pp", m0_readdatavalid, 1);
    chk("t4_m0_wait_pp", m0_waitrequest, 0);
    tick(); drv_rdv = 1'b0; #1;
    chk("t4_pend_pp", pend_count, 8);
    chk("t4_accepted_pp", acc_cnt - a0, 9);
    chk("t4_s_read_reblk", s_read, 0);
    m0_read = 1'b0;

    // controller stall during an m1 write
    do_reset();
    s_waitrequest = 1'b1;
    m1_write = 1'b1; m1_address = 22'h3ABCD; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'hC;
    tick();
    m0_write = 1'b1; m0_address = 22'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_s_write%0d", i), s_write, 1);
      chk($sformatf("t5_s_addr%0d", i), s_address, 22'h3ABCD);
      chk($sformatf("t5_s_wdata%0d", i), s_writedata, 32'hCAFEF00D);
      chk($sformatf("t5_m0_wait%0d", i), m0_waitrequest, 1);
      chk($sformatf("t5_beat%0d", i), dut.beat_cnt, 0);
      tick();
    end
    s_waitrequest = 1'b0; #1;
    chk("t5_m1_wait_go", m1_waitrequest, 0);
    chk("t5_m0_wait_go", m0_waitrequest, 1);
    tick(); m1_write = 1'b0; #1;
    chk("t5_beat_after", dut.beat_cnt, 1);
    tick(); #1;
    chk("t5_m0_granted", m0_waitrequest, 0);
    chk("t5_s_addr_m0", s_address, 22'h77);
    m0_write = 1'b0;

    // reset with reads outstanding, then late responses become orphans
    do_reset();
    issue(0, 22'h60); issue(0, 22'h61); issue(0, 22'h62);
    #1;
    chk("t6_pend3", pend_count, 3);
    reset_reset = 1'b1; #1;
    chk("t6_m0_wait_rst", m0_waitrequest, 1);
    chk("t6_s_read_rst", s_read, 0);
    tick(); reset_reset = 1'b0; m0_read = 1'b0; #1;
    chk("t6_pend_cleared", pend_count, 0);
    drv_rdata = 32'h1234; drv_rdv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t6_m0_rdv%0d", i), m0_readdatavalid, 0);
      chk($sformatf("t6_m1_rdv%0d", i), m1_readdatavalid, 0);
      tick();
    end
    drv_rdv = 1'b0; #1;
    chk("t6_orphan", err_orphan, 1);
    chk("t6_pend0", pend_count, 0);
    chk("t6_idle_m0", m0_waitrequest, 1);
    chk("t6_idle_m1", m1_waitrequest, 1);
    tick(); #1;
    chk("t6_orphan_sticky", err_orphan, 1);
    do_reset(); #1;
    chk("t6_orphan_clr", err_orphan, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 32-bit SDRAM controller Avalon-MM slave between two masters of the image-filter datapath.
- Master 0 is the filter pixel-read DMA; master 1 is the filter result-write DMA.
- Arbitration is round-robin with a bounded burst lock.
- Read responses are routed back to the issuing master through an in-order tag FIFO of outstanding reads.
- Sits between the filter engine and the SDRAM controller inside the interconnect system.

Parameters:
- ADDR_W, 22, word address width (4 banks x 4096 rows x 256 cols).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- BURST_MAX, 8, maximum accepted commands per grant before forced rotation (>=1).
- MAX_PEND, 8, maximum outstanding reads (tag FIFO depth, power of 2).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  (same set and widths as m0_*)  master 1
- s_address  out  ADDR_W  to SDRAM controller
- s_read  out  1  to SDRAM controller
- s_write  out  1  to SDRAM controller
- s_writedata  out  DATA_W  to SDRAM controller
- s_byteenable  out  DATA_W/8  to SDRAM controller
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W  controller read data
- s_readdatavalid  in  1  controller read data valid
- err_orphan  out  1  sticky: readdatavalid received with tag FIFO empty
- pend_count  out  log2(MAX_PEND)+1  outstanding read count

Behaviour:
- One clock, clk_clk; reset_reset is synchronous and active-high.
- FSM states: IDLE, GNT0, GNT1.
  - Grant register drives the command mux combinationally.
  - In IDLE, s_read/s_write = 0 and both mN_waitrequest = 1.
- Request: reqN = mN_read | mN_write. m_read and m_write are never both asserted by a master; if both are, read wins.
- IDLE transitions:
  - Only req0 -> GNT0; only req1 -> GNT1; next cycle.
  - Both requesting -> grant the master that was not granted last (last_gnt).
  - One-cycle arbitration latency.
- GNTn forwarding:
  - Master n's address, writedata, byteenable and read/write go to s_*.
  - mn_waitrequest = s_waitrequest | read_block.
  - The other master's waitrequest = 1.
- Acceptance: a command is accepted when s_read|s_write is high and s_waitrequest = 0.
  - Every acceptance increments beat_cnt.
  - A read acceptance pushes tag n into the FIFO.
- read_block = mn_read & FIFO full.
  - While read_block is high, s_read is forced to 0 and the master stalls.
  - Writes are never blocked.
- Leaving GNTn, evaluated on cycle end:
  - (a) reqn = 0, or
  - (b) an acceptance brings beat_cnt to BURST_MAX.
  - On either condition: last_gnt = n, beat_cnt = 0, and the next state is chosen by IDLE rules applied directly.
  - Rotation applies only if the other master requests; otherwise re-grant n.
  - No idle bubble when the other master is waiting.
- Responses:
  - On s_readdatavalid with FIFO non-empty: pop the head tag, pulse m<tag>_readdatavalid for one cycle, same cycle (combinational).
  - s_readdata is fanned to both mN_readdata.
- Simultaneous read push and pop in the same cycle: count is unchanged; allowed even when the FIFO is full.
- Orphan response: s_readdatavalid with FIFO empty is dropped, no mN_readdatavalid, and err_orphan is set. Only reset clears err_orphan.
- Reset, including mid-transfer:
  - state = IDLE, last_gnt = 1 (so master 0 wins the first tie), beat_cnt = 0, FIFO flushed, pend_count = 0, err_orphan = 0.
  - All s_read/s_write = 0 and mN_readdatavalid = 0; mN_waitrequest = 1 during and until granted.
- Responses arriving after a reset are orphans, by design.

Test Plan:
- Single master: m0 reads addr 0x000010, controller returns 0xDEADBEEF 3 cycles later -> s_read seen 1 cycle after request; m0_readdatavalid=1 with 0xDEADBEEF; m1_readdatavalid stays 0; pend_count 1->0.
- Tie from reset: m0 and m1 both write on the same cycle -> m0 granted first. With BURST_MAX=8 and continuous requests, m0 gets exactly 8 accepted writes, then m1 is granted with no idle cycle.
- Interleaved reads: m0 issues 3 reads, then m1 issues 2 reads, with 5-cycle controller latency -> 5 responses routed in order m0,m0,m0,m1,m1; data matches addresses.
- FIFO full: MAX_PEND=8, m0 issues 10 back-to-back reads, controller withholds responses -> 8 accepted, s_read drops to 0, m0_waitrequest=1. First response plus simultaneous push -> pend_count stays 8.
- Waitrequest: s_waitrequest held 4 cycles during an m1 write -> s_* stable, beat_cnt unchanged until acceptance; m0 stays stalled.
- Reset mid-operation: reset with 3 reads pending, then 2 late s_readdatavalid -> no mN_readdatavalid, err_orphan=1, pend_count=0, state IDLE.
